// File: rtl/wb_arbiter_pkg.sv
// Shared types for the register-file write-back arbiter.
//   data_t    : 32-bit architectural register value
//   NULL      : idle value driven on data buses
//   reg_idx_t : register-file index (x0..x31)
//   wb_req_t  : one pending write {rd, data}
package wb_arbiter_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;

  typedef logic [XLEN-1:0]      data_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam data_t    NULL     = '0;
  localparam reg_idx_t REG_ZERO = '0;

  typedef struct packed {
    reg_idx_t rd;
    data_t    data;
  } wb_req_t;

  // x0 is hardwired to zero; writes to it are architectural no-ops.
  function automatic logic is_zero_reg(input reg_idx_t r);
    return r == REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Long-latency result FIFO. Strict in-order queue of wb_req_t.
//   clk, rst   : clock, synchronous active-high reset (empties the queue)
//   push_i     : write din_i at the tail (ignored when full)
//   pop_i      : drop the head (ignored when empty)
//   din_i      : entry to enqueue
//   head_o     : current head entry (meaningful only when !empty_o)
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
//   count_o    : occupancy
//   entries_o  : raw storage, for hazard comparators
//   valid_o    : per-slot occupancy, aligned with entries_o
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  wb_req_t           din_i,
  output wb_req_t           head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o,
  output wb_req_t           entries_o [DEPTH],
  output logic [DEPTH-1:0]  valid_o
);

  wb_req_t            mem_q [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next-state for pointers, occupancy and slot-valid bits.
  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (do_push) begin
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Control state; the data array needs no reset since valid bits gate it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign entries_o = mem_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter between the pipeline WB stage and the
// long-latency (mul/div) result return.
//   clk, rst            : clock, synchronous active-high reset
//   pipe_valid/wen/rd/data : WB-stage write request (highest priority)
//   lu_valid/rd/data    : long-latency result offer; lu_ready accepts it
//   rf_wen/rd/data      : register-file write port (combinational select)
//   pipe_stall          : WB slot stolen by a forced drain this cycle
//   query_rd/query_hit  : decode hazard probe against queued results
//   fifo_count          : queued result count
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic              pipe_wen,
  input  reg_idx_t          pipe_rd,
  input  data_t             pipe_data,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  reg_idx_t          lu_rd,
  input  data_t             lu_data,
  output logic              rf_wen,
  output reg_idx_t          rf_rd,
  output data_t             rf_data,
  output logic              pipe_stall,
  input  reg_idx_t          query_rd,
  output logic              query_hit,
  output logic [CNT_W-1:0]  fifo_count
);

  wb_req_t            fifo_din;
  wb_req_t            fifo_head;
  wb_req_t            fifo_entries [DEPTH];
  logic [DEPTH-1:0]   fifo_valid;
  logic [CNT_W-1:0]   fifo_cnt;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic               pipe_req;
  logic               pipe_hit;
  logic               q_hit;
  logic [SC_W-1:0]    starve_q, starve_d;

  // Forced drain: the FIFO has been passed over STARVE_LIMIT times in a row.
  assign pipe_stall = ~rst & (starve_q == SC_W'(STARVE_LIMIT));

  assign pipe_req = ~rst & pipe_valid & pipe_wen & ~is_zero_reg(pipe_rd) & ~pipe_stall;
  assign fifo_pop = ~rst & ~pipe_req & ~fifo_empty;

  // Ready depends only on current occupancy, never on a same-cycle pop.
  assign lu_ready  = ~rst & ~fifo_full;
  // x0 results are acknowledged but never stored.
  assign fifo_push = lu_valid & lu_ready & ~is_zero_reg(lu_rd);
  assign fifo_din  = '{rd: lu_rd, data: lu_data};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (fifo_push),
    .pop_i     (fifo_pop),
    .din_i     (fifo_din),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt),
    .entries_o (fifo_entries),
    .valid_o   (fifo_valid)
  );

  // Write-port select; unselected sources never reach rf_*.
  always_comb begin
    rf_wen  = 1'b0;
    rf_rd   = REG_ZERO;
    rf_data = NULL;
    if (pipe_req) begin
      rf_wen  = 1'b1;
      rf_rd   = pipe_rd;
      rf_data = pipe_data;
    end else if (fifo_pop) begin
      rf_wen  = 1'b1;
      rf_rd   = fifo_head.rd;
      rf_data = fifo_head.data;
    end
  end

  // Starvation counter: counts consecutive non-empty cycles without a pop.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_pop) begin
      starve_d = '0;
    end else if (starve_q != SC_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + SC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Hazard comparators over occupied slots. A popping head still reports.
  always_comb begin
    q_hit    = 1'b0;
    pipe_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i] && (fifo_entries[i].rd == query_rd)) q_hit    = 1'b1;
      if (fifo_valid[i] && (fifo_entries[i].rd == pipe_rd))  pipe_hit = 1'b1;
    end
  end

  assign query_hit  = ~rst & ~is_zero_reg(query_rd) & q_hit;
  assign fifo_count = rst ? '0 : fifo_cnt;

  // The upstream scoreboard must never let a pipe write race a queued result.
  waw_pipe_vs_pending: assert property (@(posedge clk) disable iff (rst) !(pipe_req && pipe_hit));

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a queue-based model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned STARVE_LIMIT = 8;

  logic     clk = 1'b0;
  logic     rst;
  logic     pipe_valid, pipe_wen;
  reg_idx_t pipe_rd;
  data_t    pipe_data;
  logic     lu_valid, lu_ready;
  reg_idx_t lu_rd;
  data_t    lu_data;
  logic     rf_wen;
  reg_idx_t rf_rd;
  data_t    rf_data;
  logic     pipe_stall;
  reg_idx_t query_rd;
  logic     query_hit;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  wb_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_valid (pipe_valid),
    .pipe_wen   (pipe_wen),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_rd      (lu_rd),
    .lu_data    (lu_data),
    .rf_wen     (rf_wen),
    .rf_rd      (rf_rd),
    .rf_data    (rf_data),
    .pipe_stall (pipe_stall),
    .query_rd   (query_rd),
    .query_hit  (query_hit),
    .fifo_count (fifo_count)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model state: pending results in arrival order, and cycles since last drain.
  wb_req_t mq[$];
  int      m_starve = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endtask

  function automatic bit in_queue(input reg_idx_t r);
    foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle of inputs, check every output against the model, advance the model.
  task automatic cycle(input logic r, input logic pv, input logic pw, input reg_idx_t prd,
                       input data_t pd, input logic lv, input reg_idx_t lrd, input data_t ld,
                       input reg_idx_t qrd);
    logic     e_stall, e_preq, e_pop, e_wen, e_ready, e_hit;
    reg_idx_t e_rd;
    data_t    e_data;
    int       sz;
    wb_req_t  nr;
    @(negedge clk);
    cyc++;
    rst = r; pipe_valid = pv; pipe_wen = pw; pipe_rd = prd; pipe_data = pd;
    lu_valid = lv; lu_rd = lrd; lu_data = ld; query_rd = qrd;
    #1;
    sz = mq.size();
    e_stall = 1'b0; e_preq = 1'b0; e_pop = 1'b0; e_wen = 1'b0;
    e_ready = 1'b0; e_hit = 1'b0; e_rd = '0; e_data = '0;
    if (!r) begin
      e_stall = (m_starve == STARVE_LIMIT);
      e_preq  = pv && pw && (prd != 0) && !e_stall;
      e_pop   = !e_preq && (sz > 0);
      e_wen   = e_preq || e_pop;
      if (e_preq) begin
        e_rd = prd; e_data = pd;
      end else if (e_pop) begin
        e_rd = mq[0].rd; e_data = mq[0].data;
      end
      e_ready = (sz < DEPTH);
      if (qrd != 0) e_hit = in_queue(qrd);
    end
    chk("rf_wen",     32'(rf_wen),     32'(e_wen));
    chk("rf_rd",      32'(rf_rd),      32'(e_rd));
    chk("rf_data",    rf_data,         e_data);
    chk("pipe_stall", 32'(pipe_stall), 32'(e_stall));
    chk("lu_ready",   32'(lu_ready),   32'(e_ready));
    chk("query_hit",  32'(query_hit),  32'(e_hit));
    chk("fifo_count", 32'(fifo_count), r ? 32'd0 : 32'(sz));
    if (r) begin
      mq.delete();
      m_starve = 0;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (lv && (sz < DEPTH) && (lrd != 0)) begin
        nr.rd = lrd; nr.data = ld;
        mq.push_back(nr);
      end
      if (sz == 0 || e_pop) m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve++;
    end
  endtask

  task automatic idle(input reg_idx_t qrd);
    cycle(1'b0, 1'b0, 1'b0, 5'd0, NULL, 1'b0, 5'd0, NULL, qrd);
  endtask

  task automatic pipe_w3(input logic lv, input reg_idx_t lrd, input data_t ld, input reg_idx_t qrd);
    cycle(1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_3000, lv, lrd, ld, qrd);
  endtask

  initial begin
    int       pipe_pct [5] = '{90, 50, 10, 100, 30};
    int       lu_pct   [5] = '{60, 30, 80, 40, 20};
    logic     r, pv, pw, lv;
    reg_idx_t prd, lrd, qrd;
    int       ph;

    rst = 1'b1; pipe_valid = 1'b0; pipe_wen = 1'b0; pipe_rd = '0; pipe_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0; query_rd = '0;

    // Reset, then a single long-latency result drained into an idle slot.
    cycle(1'b1, 1'b0, 1'b0, 5'd0, NULL, 1'b0, 5'd0, NULL, 5'd0);
    chk("t1_rst_count", 32'(fifo_count), 32'd0);
    chk("t1_rst_wen",   32'(rf_wen),     32'd0);
    cycle(1'b1, 1'b0, 1'b0, 5'd0, NULL, 1'b0, 5'd0, NULL, 5'd0);
    cycle(1'b0, 1'b0, 1'b0, 5'd0, NULL, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0);
    chk("t1_ready", 32'(lu_ready), 32'd1);
    idle(5'd0);
    chk("t1_count1", 32'(fifo_count), 32'd1);
    chk("t1_wen",    32'(rf_wen),     32'd1);
    chk("t1_rd",     32'(rf_rd),      32'd5);
    chk("t1_data",   rf_data,         32'hDEAD_BEEF);
    idle(5'd0);
    chk("t1_count0", 32'(fifo_count), 32'd0);
    chk("t1_wen0",   32'(rf_wen),     32'd0);

    // Starvation: 8 pipe wins, then one forced drain, then pipe resumes.
    pipe_w3(1'b1, 5'd9, 32'h0000_9999, 5'd0);
    chk("t2_first_rd", 32'(rf_rd), 32'd3);
    for (int k = 0; k < 8; k++) begin
      pipe_w3(1'b0, 5'd0, NULL, 5'd0);
      chk("t2_no_stall", 32'(pipe_stall), 32'd0);
      chk("t2_pipe_rd",  32'(rf_rd),      32'd3);
    end
    pipe_w3(1'b0, 5'd0, NULL, 5'd0);
    chk("t2_stall",      32'(pipe_stall), 32'd1);
    chk("t2_drain_rd",   32'(rf_rd),      32'd9);
    chk("t2_drain_data", rf_data,         32'h0000_9999);
    pipe_w3(1'b0, 5'd0, NULL, 5'd0);
    chk("t2_resume_stall", 32'(pipe_stall), 32'd0);
    chk("t2_resume_rd",    32'(rf_rd),      32'd3);
    chk("t2_resume_count", 32'(fifo_count), 32'd0);

    // Fill to full, then push+pop at count 3 holds the count.
    for (int k = 0; k < 4; k++) pipe_w3(1'b1, reg_idx_t'(10 + k), 32'hA000 + 32'(k), 5'd0);
    pipe_w3(1'b1, 5'd14, 32'h0000_B014, 5'd0);
    chk("t3_full_count", 32'(fifo_count), 32'd4);
    chk("t3_full_ready", 32'(lu_ready),   32'd0);
    cycle(1'b0, 1'b0, 1'b0, 5'd0, NULL, 1'b1, 5'd14, 32'h0000_B014, 5'd0);
    chk("t3_no_ready_on_pop", 32'(lu_ready), 32'd0);
    chk("t3_pop_rd10",        32'(rf_rd),    32'd10);
    cycle(1'b0, 1'b0, 1'b0, 5'd0, NULL, 1'b1, 5'd15, 32'h0000_B015, 5'd0);
    chk("t3_count3",  32'(fifo_count), 32'd3);
    chk("t3_pop_rd11", 32'(rf_rd),     32'd11);
    idle(5'd0);
    chk("t3_count3_hold", 32'(fifo_count), 32'd3);
    chk("t3_pop_rd12",    32'(rf_rd),      32'd12);
    idle(5'd0);
    chk("t3_pop_rd13", 32'(rf_rd), 32'd13);
    idle(5'd0);
    chk("t3_pop_rd15",   32'(rf_rd), 32'd15);
    chk("t3_pop_data15", rf_data,    32'h0000_B015);
    idle(5'd0);
    chk("t3_empty", 32'(fifo_count), 32'd0);

    // x0 targets: dropped result, ignored pipe write.
    cycle(1'b0, 1'b1, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h5678, 5'd0);
    chk("t4_wen",   32'(rf_wen),   32'd0);
    chk("t4_ready", 32'(lu_ready), 32'd1);
    idle(5'd0);
    chk("t4_count", 32'(fifo_count), 32'd0);
    chk("t4_wen2",  32'(rf_wen),     32'd0);

    // Query hits: not on push cycle, yes while queued and on pop cycle.
    pipe_w3(1'b1, 5'd7, 32'h0000_7777, 5'd7);
    chk("t5_push_nohit", 32'(query_hit), 32'd0);
    pipe_w3(1'b0, 5'd0, NULL, 5'd7);
    chk("t5_hit", 32'(query_hit), 32'd1);
    idle(5'd7);
    chk("t5_pop_hit", 32'(query_hit), 32'd1);
    chk("t5_pop_rd",  32'(rf_rd),     32'd7);
    idle(5'd7);
    chk("t5_after_pop", 32'(query_hit), 32'd0);
    pipe_w3(1'b1, 5'd8, 32'h0000_8888, 5'd0);
    pipe_w3(1'b0, 5'd0, NULL, 5'd0);
    chk("t5_q0_nohit", 32'(query_hit), 32'd0);
    pipe_w3(1'b0, 5'd0, NULL, 5'd8);
    chk("t5_q8_hit", 32'(query_hit), 32'd1);
    idle(5'd0);

    // Reset mid-operation with 3 queued and starve count 5.
    for (int k = 0; k < 3; k++) pipe_w3(1'b1, reg_idx_t'(20 + k), 32'hC000 + 32'(k), 5'd0);
    for (int k = 0; k < 3; k++) pipe_w3(1'b0, 5'd0, NULL, 5'd0);
    chk("t6_count3", 32'(fifo_count), 32'd3);
    cycle(1'b1, 1'b1, 1'b1, 5'd3, 32'h3, 1'b1, 5'd23, 32'hC023, 5'd20);
    chk("t6_rst_count", 32'(fifo_count), 32'd0);
    chk("t6_rst_wen",   32'(rf_wen),     32'd0);
    chk("t6_rst_stall", 32'(pipe_stall), 32'd0);
    idle(5'd20);
    chk("t6_post_count", 32'(fifo_count), 32'd0);
    chk("t6_post_wen",   32'(rf_wen),     32'd0);
    chk("t6_post_hit",   32'(query_hit),  32'd0);
    idle(5'd0);
    chk("t6_no_stale", 32'(rf_wen), 32'd0);

    // Randomized traffic in phases of differing pipe/lu density.
    for (int c = 0; c < 1500; c++) begin
      ph  = c / 300;
      r   = ($urandom_range(0, 199) == 0);
      pv  = ($urandom_range(0, 99) < pipe_pct[ph]);
      pw  = ($urandom_range(0, 3) != 0);
      do prd = reg_idx_t'($urandom_range(0, 31)); while (in_queue(prd));
      lv  = ($urandom_range(0, 99) < lu_pct[ph]);
      lrd = ($urandom_range(0, 15) == 0) ? 5'd0 : reg_idx_t'($urandom_range(1, 31));
      if (mq.size() > 0 && $urandom_range(0, 1) == 1)
        qrd = mq[$urandom_range(0, mq.size() - 1)].rd;
      else
        qrd = reg_idx_t'($urandom_range(0, 31));
      cycle(r, pv, pw, prd, data_t'($urandom), lv, lrd, data_t'($urandom), qrd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
